substractor_seq: RTL and testbench

//  Parametrised multi-cycle subtractor computing {o_borrow,o_sub} = i_op1 - i_op2 - i_borrow.

---
 rtl/substractor_seq_pkg.sv | 11 +
 rtl/substractor_seq_if.sv | 27 ++
 rtl/substractor_4bit.sv | 25 ++
 rtl/substractor_seq.sv | 107 ++++++++++
 tb/tb_substractor_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/substractor_seq_pkg.sv
// Shared definitions for the sequential subtractor: slice width and FSM states.
package substractor_seq_pkg;

  localparam int unsigned SUB_SLICE_W = 4;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

endpackage

// File: rtl/substractor_seq_if.sv
// Request/result bundle for the sequential subtractor.
interface substractor_seq_if #(
  parameter int unsigned WIDTH = 16
);

  logic             i_start;
  logic [WIDTH-1:0] i_op1;
  logic [WIDTH-1:0] i_op2;
  logic             i_borrow;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sub;
  logic             o_borrow;
  logic             o_overflow;
  logic             o_zero;

  modport master (
    output i_start, i_op1, i_op2, i_borrow,
    input  o_busy, o_done, o_sub, o_borrow, o_overflow, o_zero
  );

  modport slave (
    input  i_start, i_op1, i_op2, i_borrow,
    output o_busy, o_done, o_sub, o_borrow, o_overflow, o_zero
  );

endinterface

// File: rtl/substractor_4bit.sv
// Gate-level 4-bit ripple subtractor slice: {o_borrow,o_sub} = i_op1 - i_op2 - i_borrow.
module substractor_4bit
  import substractor_seq_pkg::*;
(
  input  logic [SUB_SLICE_W-1:0] i_op1,
  input  logic [SUB_SLICE_W-1:0] i_op2,
  input  logic                   i_borrow,
  output logic [SUB_SLICE_W-1:0] o_sub,
  output logic                   o_borrow
);

  logic [SUB_SLICE_W:0] bchain;

  assign bchain[0] = i_borrow;

  for (genvar i = 0; i < SUB_SLICE_W; i++) begin : g_bit
    logic diff_ab;
    assign diff_ab     = i_op1[i] ^ i_op2[i];
    assign o_sub[i]    = diff_ab ^ bchain[i];
    assign bchain[i+1] = (~i_op1[i] & i_op2[i]) | (~diff_ab & bchain[i]);
  end

  assign o_borrow = bchain[SUB_SLICE_W];

endmodule

// File: rtl/substractor_seq.sv
// Multi-cycle subtractor: one 4-bit slice per cycle through a shared slice, LSB first,
// with start/done handshake and signed-overflow / zero flags.
module substractor_seq
  import substractor_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  substractor_seq_if.slave     bus
);

  localparam int unsigned SLICES = WIDTH / SUB_SLICE_W;
  localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLICES - 1);

  if ((WIDTH % SUB_SLICE_W) != 0 || WIDTH < SUB_SLICE_W) begin : g_bad_width
    $error("substractor_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op1_sr, op2_sr;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             borrow_r;
  logic             op1_msb, op2_msb;
  logic             accept, slice_en, last_slice;

  logic [SUB_SLICE_W-1:0] sl_sub;
  logic                   sl_borrow;

  substractor_4bit u_slice (
    .i_op1    (op1_sr[SUB_SLICE_W-1:0]),
    .i_op2    (op2_sr[SUB_SLICE_W-1:0]),
    .i_borrow (borrow_r),
    .o_sub    (sl_sub),
    .o_borrow (sl_borrow)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (bus.i_start)           state_nxt = S_RUN;
      S_RUN:  if (cnt == LAST_CNT)       state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = (state == S_IDLE) && bus.i_start;
    slice_en   = (state == S_RUN);
    last_slice = slice_en && (cnt == LAST_CNT);
    bus.o_busy = (state == S_RUN);
  end

  // Accumulator with the current slice merged in; on the last slice this is the full result,
  // so outputs can be loaded in the same edge the final slice is produced.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(cnt)*SUB_SLICE_W +: SUB_SLICE_W] = sl_sub;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt            <= '0;
      op1_sr         <= '0;
      op2_sr         <= '0;
      acc            <= '0;
      borrow_r       <= 1'b0;
      op1_msb        <= 1'b0;
      op2_msb        <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_sub      <= '0;
      bus.o_borrow   <= 1'b0;
      bus.o_overflow <= 1'b0;
      bus.o_zero     <= 1'b0;
    end else begin
      bus.o_done <= last_slice;
      if (accept) begin
        op1_sr   <= bus.i_op1;
        op2_sr   <= bus.i_op2;
        borrow_r <= bus.i_borrow;
        op1_msb  <= bus.i_op1[WIDTH-1];
        op2_msb  <= bus.i_op2[WIDTH-1];
        cnt      <= '0;
      end else if (slice_en) begin
        acc      <= acc_nxt;
        borrow_r <= sl_borrow;
        op1_sr   <= op1_sr >> SUB_SLICE_W;
        op2_sr   <= op2_sr >> SUB_SLICE_W;
        cnt      <= last_slice ? '0 : cnt + 1'b1;
        if (last_slice) begin
          bus.o_sub      <= acc_nxt;
          bus.o_borrow   <= sl_borrow;
          bus.o_overflow <= (op1_msb ^ op2_msb) & (op1_msb ^ acc_nxt[WIDTH-1]);
          bus.o_zero     <= ~|acc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_substractor_seq.sv
// Directed self-checking bench for substractor_seq at WIDTH=16.
module tb_substractor_seq;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  substractor_seq_if #(.WIDTH(W)) bus ();

  substractor_seq #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accept edge; returns edges until o_done seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.o_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] es, input logic eb,
                            input logic eo, input logic ez);
    chk({tag, "_sub"},  32'(bus.o_sub), 32'(es));
    chk({tag, "_brw"},  32'(bus.o_borrow), 32'(eb));
    chk({tag, "_ovf"},  32'(bus.o_overflow), 32'(eo));
    chk({tag, "_zero"}, 32'(bus.o_zero), 32'(ez));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic [15:0] es, input logic eb,
                        input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op1 = a; bus.i_op2 = b; bus.i_borrow = bin;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_op1 = 16'($urandom); bus.i_op2 = 16'($urandom); bus.i_borrow = 1'($urandom);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk_result(tag, es, eb, eo, ez);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    int lat;
    int gap;
    int pulses;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_op1 = '0; bus.i_op2 = '0; bus.i_borrow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);

    run_op("v_0m1",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("v_8km1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("v_eq",   16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("v_0b1",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("v_pmn",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op("v_b1",   16'h5678, 16'h1234, 1'b1, 16'h4443, 1'b0, 1'b0, 1'b0);
    run_op("v_neg",  16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0);

    // Second start issued so it is sampled at E2 of an in-flight op.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op1 = 16'h0100; bus.i_op2 = 16'h0001; bus.i_borrow = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op1 = 16'h0003; bus.i_op2 = 16'h0009; bus.i_borrow = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = 2;
    while (bus.o_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_lat", 32'(lat), 32'd4);
    chk_result("busy", 16'h00FF, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) pulses++;
    end
    chk("busy_pulses", 32'(pulses), 32'd0);
    chk("busy_idle", 32'(bus.o_busy), 32'd0);

    // Start held high: second op accepted in the o_done cycle.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op1 = 16'h0005; bus.i_op2 = 16'h0003; bus.i_borrow = 1'b0;
    @(negedge clk);
    bus.i_op1 = 16'h0003; bus.i_op2 = 16'h0005;
    wait_done(lat);
    chk("b2b1_lat", 32'(lat), 32'd4);
    chk_result("b2b1", 16'h0002, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("b2b_rebusy", 32'(bus.o_busy), 32'd1);
    gap = 1;
    while (bus.o_done !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", 32'(gap), 32'd5);
    chk_result("b2b2", 16'hFFFE, 1'b1, 1'b0, 1'b0);

    // Reset asserted at E2 of an op; prior outputs are non-zero.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op1 = 16'h8000; bus.i_op2 = 16'h0001; bus.i_borrow = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.o_busy), 32'd0);
    chk("mrst_done", 32'(bus.o_done), 32'd0);
    chk_result("mrst", 16'h0000, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) pulses++;
    end
    chk("mrst_nodone", 32'(pulses), 32'd0);
    run_op("post_rst", 16'hF000, 16'h0FFF, 1'b0, 16'hE001, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
